uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single UART transmitter of the UART system among NREQ client requesters.
- Accepts one DBITS-wide word per grant and launches it on the transmitter with a one-cycle tx_start.
- Waits for the transmitter's tx_done, then reports completion to the owning requester and rearbitrates.
- Sits between CPU-side producers and the transmitter's din/tx_start/tx_done interface. Uses the same clk/rst as the transmitter and baud generator.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DBITS, 3, data word width; must match the transmitter.
- TMO_CYCLES, 4096, watchdog limit in clk cycles while waiting for tx_done; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low. rst=0 at a rising clk edge resets the block.
- req  input  NREQ  per-requester request level; bit i set means requester i has a word pending.
- req_data  input  NREQ*DBITS  packed words; requester i occupies bits [i*DBITS +: DBITS].
- ack  output  NREQ  one-hot, one-cycle pulse: the word of requester i has been latched.
- done  output  NREQ  one-hot, one-cycle pulse: the word of requester i has been fully transmitted.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- din  output  DBITS  word to the transmitter; held stable from tx_start until the grant ends.
- tx_done  input  1  transmitter completion pulse.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
- err  output  1  sticky timeout flag; constant 0 when UART_ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (rst=0 at edge) produces:
  - state=IDLE
  - ack=0, done=0, tx_start=0, din=0, busy=0, grant_id=0, err=0
  - round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset mid-transfer abandons the word silently: no done pulse. The transmitter shares rst.
- All outputs are registered.
- States: IDLE, START, WAIT.
- IDLE:
  - If req != 0 at an edge, select the first set bit searching upward from last+1, wrapping modulo NREQ. Call it g.
  - At that edge: latch din=req_data[g], set grant_id=g, go to START.
  - If req == 0, stay in IDLE.
- START (exactly one cycle):
  - tx_start=1, ack[g]=1, busy=1.
  - Next state is WAIT.
- WAIT:
  - tx_start=0. din and grant_id are held.
  - On tx_done=1 at an edge: done[g]=1 for the next cycle, last=g, state=IDLE.
  - The done cycle is therefore an IDLE cycle. Arbitration for the next word occurs in that same IDLE cycle (edge at its end).
- Latency:
  - req sampled high in IDLE at edge k gives tx_start/ack in cycle k+1.
  - tx_done at edge m gives done in cycle m+1.
  - Minimum gap between a done pulse and the next tx_start is 1 cycle.
- Sampling of req and req_data:
  - Both are sampled only at the arbitration edge in IDLE.
  - Changes in START/WAIT are ignored. Dropping req after ack has no effect.
  - Requesters must hold req_data valid while req=1, until they see ack.
  - A requester re-asserting req after done is served in round-robin order, so no requester starves.
- tx_done outside WAIT (in IDLE or START) is ignored. No done pulse is produced.
- A single requester continuously requesting is granted back-to-back. The pointer wraps to the same index.
- ack and done are never asserted for more than one requester in the same cycle.

Optional Feature:
- Macro name: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TMO_CYCLES-1 without tx_done: set err=1 (sticky until reset), set last=g, return to IDLE, and do not pulse done[g].
  - tx_done on the same edge as expiry wins: normal done, err unchanged.
- Undefined:
  - No counter. WAIT waits indefinitely for tx_done.
  - err is tied to 0.

Test Plan:
1. Reset with rst=0 for 3 cycles, req=4'b1111 -> all outputs 0, busy=0. After release, first ack is on requester 0 with din=req_data[2:0].
2. Single word: req=4'b0100, word 3'b101; model tx_done 20 cycles after tx_start -> ack[2] and tx_start in the same cycle, din=3'b101 stable, done[2] exactly 1 cycle after tx_done, busy falls with done.
3. Round robin: req=4'b1111 held, distinct words per requester -> grant order 0,1,2,3,0; each tx_start exactly 1 cycle after the previous done.
4. Mid-operation changes: during WAIT, change req_data[2] and drop req[2]; pulse tx_done in IDLE -> din unchanged, transfer completes normally, the stray tx_done yields no done pulse.
5. Reset in WAIT: rst=0 for 1 cycle while WAIT with grant 1 -> no done[1], state IDLE, pointer reset so the next grant with req=4'b1010 goes to 1.
6. With UART_ARB_TIMEOUT_EN and TMO_CYCLES=16, never send tx_done -> err=1 after 16 WAIT cycles, no done pulse, next grant goes to the next requester. err stays 1 until reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sequencer that shares one UART transmitter among
//               NREQ requesters. Each grant latches one DBITS-wide word,
//               launches it with a one-cycle tx_start, waits for tx_done,
//               then pulses done to the owner and rearbitrates.
//               Optional macro UART_ARB_TIMEOUT_EN adds a tx_done watchdog
//               (TMO_CYCLES) with a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int DBITS      = 3,
    parameter int TMO_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DBITS-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           done,
    output logic                      tx_start,
    output logic [DBITS-1:0]          din,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      err
);

    localparam int                c_IW   = $clog2(NREQ);
    localparam logic [c_IW:0]     c_NREQ = (c_IW+1)'(NREQ);
    localparam logic [c_IW-1:0]   c_LAST_RST = c_IW'(NREQ - 1);
    localparam logic [NREQ-1:0]   c_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IW-1:0]    r_last;
    logic [c_IW-1:0]    w_last_nxt;
    logic [NREQ-1:0]    r_ack;
    logic [NREQ-1:0]    w_ack_nxt;
    logic [NREQ-1:0]    r_done;
    logic [NREQ-1:0]    w_done_nxt;
    logic               r_tx_start;
    logic               w_tx_start_nxt;
    logic [DBITS-1:0]   r_din;
    logic [DBITS-1:0]   w_din_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [c_IW-1:0]    r_grant_id;
    logic [c_IW-1:0]    w_grant_id_nxt;

    logic               w_found;
    logic [c_IW-1:0]    w_pick;
    logic [c_IW:0]      w_sum;
    logic [DBITS-1:0]   w_word;
    logic               w_tmo_fire;

    // Round-robin search: walk downward from last+NREQ to last+1 so the
    // last hit is the nearest set request above the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (c_IW+1)'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (req[w_sum[c_IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_IW-1:0];
            end
        end
    end

    assign w_word = req_data[w_pick*DBITS +: DBITS];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               c_TW       = $clog2(TMO_CYCLES);
    localparam logic [c_TW-1:0]  c_TMO_LAST = c_TW'(TMO_CYCLES - 1);

    logic [c_TW-1:0] r_tmo_cnt;
    logic            r_err;

    // Watchdog counter: cleared on the way into WAIT, counts WAIT cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_START) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_fire = (r_state == S_WAIT) && (r_tmo_cnt == c_TMO_LAST);

    // Sticky error: only a timeout that is not rescued by a same-edge tx_done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_tmo_fire && !tx_done) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_CYCLES;
    assign w_tmo_fire   = 1'b0;
    assign err          = 1'b0;
`endif

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_ack_nxt      = '0;
        w_done_nxt     = '0;
        w_tx_start_nxt = 1'b0;
        w_din_nxt      = r_din;
        w_grant_id_nxt = r_grant_id;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_START;
                    w_din_nxt      = w_word;
                    w_grant_id_nxt = w_pick;
                    w_tx_start_nxt = 1'b1;
                    w_ack_nxt      = c_ONE << w_pick;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    w_done_nxt  = c_ONE << r_grant_id;
                    w_last_nxt  = r_grant_id;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_fire) begin
                    w_last_nxt  = r_grant_id;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_last     <= c_LAST_RST;
            r_ack      <= '0;
            r_done     <= '0;
            r_tx_start <= 1'b0;
            r_din      <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_ack      <= w_ack_nxt;
            r_done     <= w_done_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_din      <= w_din_nxt;
            r_busy     <= w_busy_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    assign ack      = r_ack;
    assign done     = r_done;
    assign tx_start = r_tx_start;
    assign din      = r_din;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Randomized self-checking bench for uart_tx_arbiter with a
//               transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ       = 4;
    localparam int DBITS      = 3;
    localparam int TMO_CYCLES = 16;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*DBITS-1:0]   req_data;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0]         done;
    logic                    tx_start;
    logic [DBITS-1:0]        din;
    logic                    tx_done;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    err;

    int n_vec;
    int n_err;
    int m_last;
    int m_err;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .DBITS      (DBITS),
        .TMO_CYCLES (TMO_CYCLES)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .tx_start (tx_start),
        .din      (din),
        .tx_done  (tx_done),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: first requester above the pointer, wrapping around.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        logic [NREQ-1:0] sh;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i  = (last + k) % NREQ;
            sh = r >> i;
            if (sh[0]) return i;
        end
        return 0;
    endfunction

    function automatic logic [DBITS-1:0] word_of(input logic [NREQ*DBITS-1:0] d, input int g);
        logic [NREQ*DBITS-1:0] t;
        t = d >> (g * DBITS);
        return t[DBITS-1:0];
    endfunction

    // Present a request set in IDLE; the next cycle must be the START cycle.
    task automatic start_grant(input logic [NREQ-1:0] r, input logic [NREQ*DBITS-1:0] d,
                               output int g, output logic [DBITS-1:0] w);
        req      = r;
        req_data = d;
        g        = rr_pick(m_last, r);
        w        = word_of(d, g);
        @(negedge clk);
        check_val("start.tx_start", 32'(tx_start), 32'd1);
        check_val("start.ack",      32'(ack),      32'd1 << g);
        check_val("start.din",      32'(din),      32'(w));
        check_val("start.grant_id", 32'(grant_id), 32'(g));
        check_val("start.busy",     32'(busy),     32'd1);
        check_val("start.done",     32'(done),     32'd0);
        check_val("start.err",      32'(err),      32'(m_err));
    endtask

    // Let the word sit in WAIT for 'delay' cycles, then complete it.
    task automatic finish_grant(input int g, input logic [DBITS-1:0] w, input int delay,
                                input bit stray, input bit mutate);
        if (stray) tx_done = 1'b1;
        if (mutate) begin
            req      = NREQ'($urandom);
            req_data = (NREQ*DBITS)'($urandom);
        end
        @(negedge clk);
        tx_done = 1'b0;
        check_val("wait.tx_start", 32'(tx_start), 32'd0);
        check_val("wait.ack",      32'(ack),      32'd0);
        check_val("wait.busy",     32'(busy),     32'd1);
        check_val("wait.din",      32'(din),      32'(w));
        check_val("wait.done",     32'(done),     32'd0);
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            check_val("wait.din_hold", 32'(din),  32'(w));
            check_val("wait.busy",     32'(busy), 32'd1);
            check_val("wait.done",     32'(done), 32'd0);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_val("done.pulse",    32'(done),     32'd1 << g);
        check_val("done.busy",     32'(busy),     32'd0);
        check_val("done.tx_start", 32'(tx_start), 32'd0);
        check_val("done.grant_id", 32'(grant_id), 32'(g));
        check_val("done.din",      32'(din),      32'(w));
        check_val("done.err",      32'(err),      32'(m_err));
        m_last = g;
    endtask

    // tx_done while IDLE must not produce a done pulse.
    task automatic idle_stray();
        req     = '0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_val("stray.done",     32'(done),     32'd0);
        check_val("stray.busy",     32'(busy),     32'd0);
        check_val("stray.tx_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        check_val("stray.done2",    32'(done),     32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".ack"},      32'(ack),      32'd0);
        check_val({tag, ".done"},     32'(done),     32'd0);
        check_val({tag, ".tx_start"}, 32'(tx_start), 32'd0);
        check_val({tag, ".din"},      32'(din),      32'd0);
        check_val({tag, ".busy"},     32'(busy),     32'd0);
        check_val({tag, ".grant_id"}, 32'(grant_id), 32'd0);
        check_val({tag, ".err"},      32'(err),      32'd0);
    endtask

    initial begin
        int               g;
        logic [DBITS-1:0] w;
        logic [NREQ-1:0]  r;
        n_vec    = 0;
        n_err    = 0;
        m_last   = NREQ - 1;
        m_err    = 0;
        rst      = 1'b0;
        req      = '1;
        req_data = (NREQ*DBITS)'($urandom);
        tx_done  = 1'b0;

        // Reset held three cycles with every request pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rst = 1'b1;

        // Round robin with all requests held: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            start_grant('1, {3'd4, 3'd3, 3'd2, 3'd1}, g, w);
            finish_grant(g, w, 3, 1'b0, 1'b0);
        end

        // Single word on requester 2.
        start_grant(4'b0100, {3'd0, 3'b101, 3'd0, 3'd0}, g, w);
`ifdef UART_ARB_TIMEOUT_EN
        finish_grant(g, w, 10, 1'b0, 1'b0);
`else
        finish_grant(g, w, 20, 1'b0, 1'b0);
`endif

        // Inputs changing during WAIT, stray tx_done in START and in IDLE.
        start_grant(4'b0100, {3'd1, 3'b011, 3'd2, 3'd7}, g, w);
        finish_grant(g, w, 5, 1'b1, 1'b1);
        idle_stray();

        // Reset while WAIT on requester 1; pointer must return to NREQ-1.
        start_grant(4'b0100, {3'd1, 3'd6, 3'd2, 3'd7}, g, w);
        finish_grant(g, w, 2, 1'b0, 1'b0);
        start_grant(4'b0010, {3'd1, 3'd6, 3'd5, 3'd7}, g, w);
        @(negedge clk);
        check_val("rstwait.busy", 32'(busy), 32'd1);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("rstwait");
        m_last = NREQ - 1;
        m_err  = 0;
        @(negedge clk);
        check_val("rstwait.no_done", 32'(done), 32'd0);
        start_grant(4'b1010, {3'd2, 3'd4, 3'd5, 3'd6}, g, w);
        finish_grant(g, w, 4, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            start_grant(r, (NREQ*DBITS)'($urandom), g, w);
            finish_grant(g, w, $urandom_range(1, 14), ($urandom % 4) == 0, 1'b1);
            if (($urandom % 4) == 0) idle_stray();
        end

`ifdef UART_ARB_TIMEOUT_EN
        // tx_done on the expiry edge completes normally.
        start_grant(NREQ'($urandom_range(1, (1 << NREQ) - 1)), (NREQ*DBITS)'($urandom), g, w);
        finish_grant(g, w, TMO_CYCLES, 1'b0, 1'b0);

        // No tx_done at all: timeout after TMO_CYCLES WAIT cycles.
        start_grant('1, (NREQ*DBITS)'($urandom), g, w);
        for (int i = 0; i < TMO_CYCLES; i++) begin
            @(negedge clk);
            check_val("tmo.busy", 32'(busy), 32'd1);
            check_val("tmo.err",  32'(err),  32'd0);
        end
        @(negedge clk);
        check_val("tmo.busy_drop", 32'(busy), 32'd0);
        check_val("tmo.err_set",   32'(err),  32'd1);
        check_val("tmo.no_done",   32'(done), 32'd0);
        m_last = g;
        m_err  = 1;
        for (int i = 0; i < 3; i++) begin
            start_grant('1, (NREQ*DBITS)'($urandom), g, w);
            finish_grant(g, w, $urandom_range(1, 8), 1'b0, 1'b0);
        end
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        check_val("tmo.err_clear", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
